// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural Z/V/N flag register and sticky halt bit.
// Optional build macro FLAG_FWD_EN forwards next-state flags combinationally to the flag outputs.
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic [3:0]        ex_opcode_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic              ex_ovfl_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_wen_i,
  input  logic [DATA_W-1:0] ex_store_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              mem_valid_o,
  output logic [3:0]        mem_opcode_o,
  output logic [DATA_W-1:0] mem_result_o,
  output logic [REG_AW-1:0] mem_rd_o,
  output logic              mem_wen_o,
  output logic [DATA_W-1:0] mem_store_data_o,
  output logic              flag_z_o,
  output logic              flag_v_o,
  output logic              flag_n_o,
  output logic              halted_o
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    FU_NONE  = 2'd0,
    FU_ZONLY = 2'd1,
    FU_ZVN   = 2'd2
  } flag_upd_e;

  // Which flags an opcode is allowed to write.
  function automatic flag_upd_e flag_class(input logic [3:0] op);
    flag_upd_e cls;
    case (op)
      OP_ADD, OP_SUB:                 cls = FU_ZVN;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: cls = FU_ZONLY;
      default:                        cls = FU_NONE;
    endcase
    return cls;
  endfunction

  logic              mem_valid_q,      mem_valid_d;
  logic [3:0]        mem_opcode_q,     mem_opcode_d;
  logic [DATA_W-1:0] mem_result_q,     mem_result_d;
  logic [REG_AW-1:0] mem_rd_q,         mem_rd_d;
  logic              mem_wen_q,        mem_wen_d;
  logic [DATA_W-1:0] mem_store_data_q, mem_store_data_d;
  logic              flag_z_q,         flag_z_d;
  logic              flag_v_q,         flag_v_d;
  logic              flag_n_q,         flag_n_d;
  logic              halted_q,         halted_d;

  logic              capture_s;
  logic              take_s;

  // Next-state: stall holds everything, halt/flush/invalid capture a zeroed bubble.
  always_comb begin
    capture_s        = ~stall_i & ~halted_q & ~flush_i;
    take_s           = capture_s & ex_valid_i;
    mem_valid_d      = mem_valid_q;
    mem_opcode_d     = mem_opcode_q;
    mem_result_d     = mem_result_q;
    mem_rd_d         = mem_rd_q;
    mem_wen_d        = mem_wen_q;
    mem_store_data_d = mem_store_data_q;
    flag_z_d         = flag_z_q;
    flag_v_d         = flag_v_q;
    flag_n_d         = flag_n_q;
    halted_d         = halted_q;

    if (stall_i) begin
      mem_valid_d = mem_valid_q;
    end else if (take_s) begin
      mem_valid_d      = 1'b1;
      mem_opcode_d     = ex_opcode_i;
      mem_result_d     = ex_result_i;
      mem_rd_d         = ex_rd_i;
      mem_wen_d        = ex_wen_i;
      mem_store_data_d = ex_store_data_i;
    end else begin
      mem_valid_d      = 1'b0;
      mem_opcode_d     = 4'b0000;
      mem_result_d     = {DATA_W{1'b0}};
      mem_rd_d         = {REG_AW{1'b0}};
      mem_wen_d        = 1'b0;
      mem_store_data_d = {DATA_W{1'b0}};
    end

    if (take_s) begin
      case (flag_class(ex_opcode_i))
        FU_ZVN: begin
          flag_z_d = (ex_result_i == {DATA_W{1'b0}});
          flag_n_d = ex_result_i[DATA_W-1];
          flag_v_d = ex_ovfl_i;
        end
        FU_ZONLY: begin
          flag_z_d = (ex_result_i == {DATA_W{1'b0}});
        end
        default: begin
          flag_z_d = flag_z_q;
        end
      endcase
      halted_d = halted_q | (ex_opcode_i == OP_HLT);
    end else begin
      halted_d = halted_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_valid_q      <= 1'b0;
      mem_opcode_q     <= 4'b0000;
      mem_result_q     <= {DATA_W{1'b0}};
      mem_rd_q         <= {REG_AW{1'b0}};
      mem_wen_q        <= 1'b0;
      mem_store_data_q <= {DATA_W{1'b0}};
      flag_z_q         <= 1'b0;
      flag_v_q         <= 1'b0;
      flag_n_q         <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_opcode_q     <= mem_opcode_d;
      mem_result_q     <= mem_result_d;
      mem_rd_q         <= mem_rd_d;
      mem_wen_q        <= mem_wen_d;
      mem_store_data_q <= mem_store_data_d;
      flag_z_q         <= flag_z_d;
      flag_v_q         <= flag_v_d;
      flag_n_q         <= flag_n_d;
      halted_q         <= halted_d;
    end
  end

  assign mem_valid_o      = mem_valid_q;
  assign mem_opcode_o     = mem_opcode_q;
  assign mem_result_o     = mem_result_q;
  assign mem_rd_o         = mem_rd_q;
  assign mem_wen_o        = mem_wen_q;
  assign mem_store_data_o = mem_store_data_q;
  assign halted_o         = halted_q;

`ifdef FLAG_FWD_EN
  // Next-state flags give ID same-cycle visibility; reset still forces them low.
  assign flag_z_o = rst_i ? 1'b0 : flag_z_d;
  assign flag_v_o = rst_i ? 1'b0 : flag_v_d;
  assign flag_n_o = rst_i ? 1'b0 : flag_n_d;
`else
  assign flag_z_o = flag_z_q;
  assign flag_v_o = flag_v_q;
  assign flag_n_o = flag_n_q;
`endif

endmodule
